// File: rtl/aurora_rx_initializer.sv
// Receive-side Aurora channel initializer: watches decoded ordered sets per lane and
// walks the channel through RESET -> ALIGN -> BOND -> VERIFY -> READY.

module aurora_rx_lane_align #(
  parameter int ALIGN_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       ctrl,
  input  logic       err,
  output logic       full_nxt,
  output logic       aligned
);
  localparam int            CW   = $clog2(ALIGN_COUNT) + 1;
  localparam logic [CW-1:0] CMAX = CW'(ALIGN_COUNT);

  logic [CW-1:0] cnt, cnt_upd;

  // clr is kept out of full_nxt so the FSM's next-state logic never loops back through it
  always_comb begin
    cnt_upd = cnt;
    if (en) begin
      if (err)                                              cnt_upd = '0;
      else if (ctrl && data == 8'hBC && cnt != CMAX)         cnt_upd = cnt + 1'b1;
    end
  end

  assign full_nxt = (cnt_upd == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      aligned <= 1'b0;
    end else begin
      cnt     <= clr ? '0 : cnt_upd;
      aligned <= ~clr & full_nxt;
    end
  end
endmodule

module aurora_rx_initializer #(
  parameter int MAX_LINKS       = 4,
  parameter int ALIGN_COUNT     = 8,
  parameter int BOND_COUNT      = 4,
  parameter int VERIFY_COUNT    = 16,
  parameter int ERR_LIMIT       = 4,
  parameter int ERR_WINDOW      = 64,
  parameter int RESET_CYCLES    = 4,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      single_lane,
  input  logic [MAX_LINKS-1:0][7:0] data_in,
  input  logic [MAX_LINKS-1:0]      ctrl_in,
  input  logic [MAX_LINKS-1:0]      code_err,
  output logic [MAX_LINKS-1:0]      lane_aligned,
  output logic                      simplex_aligned,
  output logic                      simplex_bonded,
  output logic                      simplex_verified,
  output logic                      simplex_reset,
  output logic                      channel_up
);
  localparam int BW = $clog2(BOND_COUNT) + 1;
  localparam int VW = $clog2(VERIFY_COUNT) + 1;
  localparam int EW = $clog2(ERR_LIMIT) + 1;
  localparam int CW = $clog2(ERR_WINDOW) + 1;
  localparam int RW = $clog2(WATCHDOG_CYCLES) + 1;

  localparam logic [BW-1:0] BOND_MAX = BW'(BOND_COUNT);
  localparam logic [VW-1:0] VER_MAX  = VW'(VERIFY_COUNT);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);
  localparam logic [CW-1:0] WIN_LAST = CW'(ERR_WINDOW - 1);
  localparam logic [RW-1:0] RES_MAX  = RW'(WATCHDOG_CYCLES);
  localparam logic [RW-1:0] WD_LAST  = RW'(WATCHDOG_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {ST_RESET, ST_ALIGN, ST_BOND, ST_VERIFY, ST_READY} state_t;

  state_t         state, fwd, nxt;
  logic           sl_q;
  logic [RW-1:0]  res_cnt;
  logic [BW-1:0]  bond_cnt, bond_nxt;
  logic [VW-1:0]  ver_cnt, ver_nxt;
  logic [EW-1:0]  err_cnt, err_nxt;
  logic [CW-1:0]  clean_cnt, clean_nxt;

  logic [MAX_LINKS-1:0] active, is_a, is_v, lane_full;
  logic a_all, a_any, v_all, v_any, err_any, wd_trip, err_trip, sl_chg;

  assign active = sl_q ? MAX_LINKS'(1) : {MAX_LINKS{1'b1}};

  for (genvar i = 0; i < MAX_LINKS; i++) begin : g_lane
    assign is_a[i] = ctrl_in[i] & ~code_err[i] & (data_in[i] == 8'h7C);
    assign is_v[i] = ctrl_in[i] & ~code_err[i] & (data_in[i] == 8'h9C);

    aurora_rx_lane_align #(.ALIGN_COUNT(ALIGN_COUNT)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (nxt == ST_RESET),
      .en       ((state == ST_ALIGN) & active[i]),
      .data     (data_in[i]),
      .ctrl     (ctrl_in[i]),
      .err      (code_err[i]),
      .full_nxt (lane_full[i]),
      .aligned  (lane_aligned[i])
    );
  end

  assign a_all   = &(is_a | ~active);
  assign a_any   = |(is_a & active);
  assign v_all   = &(is_v | ~active);
  assign v_any   = |(is_v & active);
  assign err_any = |(code_err & active);

  always_comb begin
    fwd       = state;
    bond_nxt  = bond_cnt;
    ver_nxt   = ver_cnt;
    err_nxt   = err_cnt;
    clean_nxt = clean_cnt;
    unique case (state)
      ST_RESET:  if (res_cnt == RST_LAST) fwd = ST_ALIGN;
      ST_ALIGN:  if (&(lane_full | ~active)) fwd = sl_q ? ST_VERIFY : ST_BOND;
      ST_BOND: begin
        if (a_all) begin
          if (bond_cnt != BOND_MAX) bond_nxt = bond_cnt + 1'b1;
        end else if (a_any) bond_nxt = '0;
        if (bond_nxt == BOND_MAX) fwd = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (v_all) begin
          if (ver_cnt != VER_MAX) ver_nxt = ver_cnt + 1'b1;
        end else if (v_any) ver_nxt = '0;
        if (ver_nxt == VER_MAX) fwd = ST_READY;
      end
      default: ;
    endcase

    // error monitor; a full clean window forgives earlier errors
    if (state inside {ST_BOND, ST_VERIFY, ST_READY}) begin
      if (err_any) begin
        clean_nxt = '0;
        if (err_cnt != ERR_MAX) err_nxt = err_cnt + 1'b1;
      end else if (clean_cnt == WIN_LAST) begin
        clean_nxt = '0;
        err_nxt   = '0;
      end else clean_nxt = clean_cnt + 1'b1;
    end

    wd_trip  = (state inside {ST_ALIGN, ST_BOND, ST_VERIFY}) && (res_cnt == WD_LAST);
    err_trip = (err_nxt == ERR_MAX);
    sl_chg   = (state != ST_RESET) && (single_lane != sl_q);
    nxt      = (wd_trip || err_trip || sl_chg) ? ST_RESET : fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_RESET;
      sl_q             <= 1'b0;
      res_cnt          <= '0;
      bond_cnt         <= '0;
      ver_cnt          <= '0;
      err_cnt          <= '0;
      clean_cnt        <= '0;
      simplex_reset    <= 1'b1;
      simplex_aligned  <= 1'b0;
      simplex_bonded   <= 1'b0;
      simplex_verified <= 1'b0;
      channel_up       <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_RESET) sl_q <= single_lane;
      if (nxt != state)            res_cnt <= '0;
      else if (res_cnt != RES_MAX) res_cnt <= res_cnt + 1'b1;
      if (nxt == ST_RESET) begin
        bond_cnt  <= '0;
        ver_cnt   <= '0;
        err_cnt   <= '0;
        clean_cnt <= '0;
      end else begin
        bond_cnt  <= bond_nxt;
        ver_cnt   <= ver_nxt;
        err_cnt   <= err_nxt;
        clean_cnt <= clean_nxt;
      end
      simplex_reset    <= (nxt == ST_RESET);
      simplex_aligned  <= (nxt inside {ST_BOND, ST_VERIFY, ST_READY});
      simplex_bonded   <= (nxt inside {ST_VERIFY, ST_READY});
      simplex_verified <= (nxt == ST_READY);
      channel_up       <= (nxt == ST_READY);
    end
  end
endmodule

// File: tb/tb_aurora_rx_initializer.sv
// Directed + randomized bench for aurora_rx_initializer against a cycle-level behavioural model.
module tb_aurora_rx_initializer;
  localparam int L = 4, AC = 8, BC = 4, VC = 16, EL = 4, EW = 64, RC = 4, WD = 4096;

  logic clk = 1'b0, rst_n = 1'b0, single_lane = 1'b1;
  logic [L-1:0][7:0] data_in;
  logic [L-1:0] ctrl_in, code_err, lane_aligned;
  logic sa, sb, sv, sr, cu;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  aurora_rx_initializer #(
    .MAX_LINKS(L), .ALIGN_COUNT(AC), .BOND_COUNT(BC), .VERIFY_COUNT(VC), .ERR_LIMIT(EL),
    .ERR_WINDOW(EW), .RESET_CYCLES(RC), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .single_lane(single_lane), .data_in(data_in), .ctrl_in(ctrl_in),
    .code_err(code_err), .lane_aligned(lane_aligned), .simplex_aligned(sa), .simplex_bonded(sb),
    .simplex_verified(sv), .simplex_reset(sr), .channel_up(cu)
  );

  // behavioural model: m_res counts cycles already spent in the current state
  typedef enum int {M_RST, M_ALN, M_BND, M_VER, M_RDY} mst_t;
  mst_t m_st;
  int   m_res, m_bond, m_ver, m_err, m_clean;
  bit   m_sl;
  int   m_lane [L];

  task automatic model_reset();
    m_st = M_RST; m_res = 0; m_bond = 0; m_ver = 0; m_err = 0; m_clean = 0; m_sl = 0;
    for (int i = 0; i < L; i++) m_lane[i] = 0;
  endtask

  function automatic bit clean_sym(int i, logic [7:0] s);
    return ctrl_in[i] && !code_err[i] && data_in[i] == s;
  endfunction

  task automatic model_edge();
    mst_t nxt;
    bit   kill;
    int   n, na, nv, ne, al;
    nxt = m_st; kill = 0; n = m_sl ? 1 : L; na = 0; nv = 0; ne = 0; al = 0;
    m_res++;
    for (int i = 0; i < n; i++) begin
      na += int'(clean_sym(i, 8'h7C));
      nv += int'(clean_sym(i, 8'h9C));
      ne += int'(code_err[i]);
    end
    case (m_st)
      M_RST: begin
        m_sl = single_lane;
        if (m_res == RC) nxt = M_ALN;
      end
      M_ALN: begin
        for (int i = 0; i < n; i++) begin
          if (code_err[i]) m_lane[i] = 0;
          else if (clean_sym(i, 8'hBC) && m_lane[i] < AC) m_lane[i]++;
          if (m_lane[i] == AC) al++;
        end
        if (al == n) nxt = m_sl ? M_VER : M_BND;
      end
      M_BND: begin
        if (na == n) m_bond = (m_bond < BC) ? m_bond + 1 : m_bond;
        else if (na > 0) m_bond = 0;
        if (m_bond == BC) nxt = M_VER;
      end
      M_VER: begin
        if (nv == n) m_ver = (m_ver < VC) ? m_ver + 1 : m_ver;
        else if (nv > 0) m_ver = 0;
        if (m_ver == VC) nxt = M_RDY;
      end
      default: ;
    endcase
    if (m_st inside {M_BND, M_VER, M_RDY}) begin
      if (ne > 0) begin
        m_clean = 0;
        if (m_err < EL) m_err++;
      end else begin
        m_clean++;
        if (m_clean == EW) begin m_clean = 0; m_err = 0; end
      end
      if (m_err == EL) kill = 1;
    end
    if (m_st inside {M_ALN, M_BND, M_VER} && m_res == WD) kill = 1;
    if (m_st != M_RST && single_lane != m_sl) kill = 1;
    if (kill) nxt = M_RST;
    if (nxt != m_st) m_res = 0;
    if (nxt == M_RST) begin
      m_bond = 0; m_ver = 0; m_err = 0; m_clean = 0;
      for (int i = 0; i < L; i++) m_lane[i] = 0;
    end
    m_st = nxt;
  endtask

  function automatic logic [L+4:0] exp_vec();
    logic [L-1:0] la;
    la = '0;
    for (int i = 0; i < (m_sl ? 1 : L); i++) la[i] = (m_lane[i] == AC);
    return {la, m_st inside {M_BND, M_VER, M_RDY}, m_st inside {M_VER, M_RDY},
            m_st == M_RDY, m_st == M_RST, m_st == M_RDY};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk(tag, 32'({lane_aligned, sa, sb, sv, sr, cu}), 32'(exp_vec()));
  endtask

  // inactive lanes get junk, including errors and ordered sets, which must be ignored
  task automatic set_lanes(input logic [7:0] sym, input int err_pct);
    for (int i = 0; i < L; i++) begin
      if (single_lane && i > 0) begin
        data_in[i] = 8'($urandom); ctrl_in[i] = 1'($urandom); code_err[i] = 1'($urandom);
      end else begin
        data_in[i] = sym; ctrl_in[i] = 1'b1; code_err[i] = ($urandom_range(99) < err_pct);
      end
    end
  endtask

  initial begin
    logic [7:0] alt [3];
    logic [7:0] pool [4];
    int t_rst, t_al, t_bd, t_up, t0, t1;
    logic [7:0] sym;
    alt  = '{8'hBC, 8'h9C, 8'h1C};
    pool = '{8'hBC, 8'h7C, 8'h9C, 8'h1C};

    // async reset state
    model_reset();
    set_lanes(8'hBC, 0);
    #12;
    chk("reset_state", 32'({lane_aligned, sa, sb, sv, sr, cu}), 32'({{L{1'b0}}, 5'b00010}));
    rst_n = 1'b1;

    // single lane: /K/ then /V/, check exact milestone cycles
    t_rst = -1; t_al = -1; t_bd = -1; t_up = -1;
    for (int t = 1; t <= 30; t++) begin
      set_lanes(t <= RC + AC ? 8'hBC : 8'h9C, 0);
      tick("single_init");
      if (!sr && t_rst < 0) t_rst = t;
      if (sa && t_al < 0) t_al = t;
      if (sb && t_bd < 0) t_bd = t;
      if (cu && t_up < 0) t_up = t;
    end
    chk("reset_len", t_rst, RC);
    chk("aligned_at", t_al, RC + AC);
    chk("bonded_at", t_bd, RC + AC);
    chk("up_at", t_up, RC + AC + VC);

    // READY: 4 errors closer than the window -> RESET
    for (int e = 0; e < EL; e++) begin
      for (int g = 0; g < int'($urandom_range(60, 5)); g++) begin
        set_lanes(8'h1C, 0); tick("err_gap");
      end
      set_lanes(8'h1C, 0); code_err[0] = 1'b1; tick("err_hit");
    end
    chk("err_reset_sr", sr, 1);
    chk("err_reset_up", cu, 0);

    // multi lane: noisy /K/, clean /K/, partial /A/, full /A/, /V/
    single_lane = 1'b0;
    for (int t = 0; t < 20; t++) begin set_lanes(8'hBC, 5); tick("multi_kerr"); end
    for (int t = 0; t < 10; t++) begin set_lanes(8'hBC, 0); tick("multi_k"); end
    chk("bond_entered", {sa, sb}, 2'b10);
    for (int t = 0; t < 10; t++) begin
      set_lanes(8'h7C, 0); data_in[1] = alt[$urandom_range(2)];
      tick("partial_a");
      chk("bond_cnt_partial", 32'(dut.bond_cnt), 0);
    end
    for (int t = 1; t <= BC; t++) begin
      set_lanes(8'h7C, 0); tick("full_a");
      chk("bonded_edge", sb, (t == BC));
    end
    for (int t = 0; t < VC; t++) begin set_lanes(8'h9C, 0); tick("multi_v"); end
    chk("multi_up", cu, 1);

    // errors spaced by a full clean window are forgiven
    for (int e = 0; e < 6; e++) begin
      set_lanes(8'h1C, 0); code_err[$urandom_range(L-1)] = 1'b1; tick("sparse_err");
      for (int g = 0; g < int'($urandom_range(80, EW)); g++) begin
        set_lanes(8'h1C, 0); tick("sparse_gap");
      end
    end
    chk("sparse_still_up", cu, 1);

    // single_lane change in READY, then in VERIFY
    single_lane = 1'b1; set_lanes(8'h1C, 0); tick("toggle_ready");
    chk("toggle_ready_sr", sr, 1);
    for (int t = 0; t < RC + AC; t++) begin set_lanes(8'hBC, 0); tick("sl_k"); end
    for (int t = 0; t < 5; t++) begin set_lanes(8'h9C, 0); tick("sl_v"); end
    chk("in_verify", {sb, sv}, 2'b10);
    single_lane = 1'b0; set_lanes(8'h9C, 0); tick("toggle_verify");
    chk("toggle_verify_sr", sr, 1);

    // watchdog: only /R/ in ALIGN
    single_lane = 1'b1;
    t0 = -1; t1 = -1;
    for (int t = 1; t <= 4300 && t1 < 0; t++) begin
      set_lanes(8'h1C, 0); tick("watchdog");
      if (!sr && t0 < 0) t0 = t;
      if (sr && t0 >= 0 && t1 < 0) t1 = t;
    end
    chk("watchdog_len", t1 - t0, WD);

    // async reset mid-VERIFY, away from any clock edge
    for (int t = 0; t < RC + AC; t++) begin set_lanes(8'hBC, 0); tick("pre_async_k"); end
    for (int t = 0; t < 3; t++) begin set_lanes(8'h9C, 0); tick("pre_async_v"); end
    chk("async_in_verify", {sb, sv}, 2'b10);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("async_reset", 32'({lane_aligned, sa, sb, sv, sr, cu}), 32'({{L{1'b0}}, 5'b00010}));
    #3 rst_n = 1'b1;

    // random soak: bursts of one ordered set with noise, errors and rare lane-mode flips
    for (int t = 0; t < 1500; t++) begin
      if (t % 20 == 0) sym = pool[$urandom_range(3)];
      if ($urandom_range(399) == 0) single_lane = ~single_lane;
      set_lanes(sym, 2);
      for (int i = 0; i < L; i++)
        if ($urandom_range(9) == 0) begin
          data_in[i] = ($urandom_range(1) != 0) ? 8'($urandom) : pool[$urandom_range(3)];
          ctrl_in[i] = 1'($urandom);
        end
      tick("soak");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
